// File: rtl/spr_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spr_io_pkg
// Brief    : Shared state encoding, SPR status bit indices and timing default
// Revision : 1.0
// ============================================================================
package spr_io_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_SHIFT_LO = 2'd1;
    localparam state_t ST_SHIFT_HI = 2'd2;
    localparam state_t ST_LATCH    = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_PEND = 1;
    localparam int STAT_OVR  = 2;

    localparam int DEF_CLK_DIV = 25;

endpackage
`default_nettype wire

// File: rtl/clk_div_tick.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_tick
// Brief    : Clearable 0..CLK_DIV-1 counter with a one-cycle terminal tick
// Revision : 1.0
// ============================================================================
module clk_div_tick
    import spr_io_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spr_serial_out.sv
`default_nettype none
// ============================================================================
// Module   : spr_serial_out
// Brief    : CPU output SPR shifted MSB-first to a 74HC595 chain, with status
// Revision : 1.0
// ============================================================================
module spr_serial_out
    import spr_io_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sprIn,
    input  logic        updateOutReg,
    input  logic        clrStatus,
    output logic [31:0] sprOut,
    output logic        serData,
    output logic        serClk,
    output logic        serLatch
);

    localparam int               BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] C_BITS = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] C_ONE  = BIT_W'(1);

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_hold;
    logic [BIT_W-1:0]  r_bits;
    logic              r_ser_data;
    logic              r_ser_clk;
    logic              r_ser_latch;
    logic              r_busy;
    logic              r_pend;
    logic              r_ovr;

    logic              w_tick;
    logic              w_div_clr;
    logic              w_latch_done;
    logic              w_load;
    logic              w_load_hold;
    logic              w_hold_wr;
    logic              w_pend_nxt;
    logic              w_ovr_set;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_shifted;
    logic              w_unused_bits;

    assign w_unused_bits = ^sprIn;

    // Reset asserts asynchronously; its release is aligned to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    clk_div_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (w_rst_n),
        .clr   (w_div_clr),
        .tick  (w_tick)
    );

    assign w_div_clr    = (r_state == ST_IDLE) || (w_state_nxt != r_state);
    assign w_latch_done = (r_state == ST_LATCH) && w_tick;
    assign w_shifted    = r_shift << 1;
    assign w_load_data  = w_load_hold ? r_hold : sprIn[DATA_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_hold = 1'b0;
        w_hold_wr   = 1'b0;
        w_pend_nxt  = r_pend;
        w_ovr_set   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (updateOutReg) begin
                    w_state_nxt = ST_SHIFT_LO;
                    w_load      = 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (w_tick) begin
                    w_state_nxt = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (w_tick) begin
                    w_state_nxt = (r_bits == C_ONE) ? ST_LATCH : ST_SHIFT_LO;
                end
            end
            ST_LATCH: begin
                if (w_tick) begin
                    // A write landing on the closing cycle beats any queued word.
                    if (updateOutReg) begin
                        w_state_nxt = ST_SHIFT_LO;
                        w_load      = 1'b1;
                        w_ovr_set   = r_pend;
                        w_pend_nxt  = 1'b0;
                    end else if (r_pend) begin
                        w_state_nxt = ST_SHIFT_LO;
                        w_load      = 1'b1;
                        w_load_hold = 1'b1;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if ((r_state != ST_IDLE) && updateOutReg && !w_latch_done) begin
            w_hold_wr  = 1'b1;
            w_pend_nxt = 1'b1;
            w_ovr_set  = r_pend;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_bits      <= '0;
            r_ser_data  <= 1'b0;
            r_ser_clk   <= 1'b0;
            r_ser_latch <= 1'b0;
            r_busy      <= 1'b0;
            r_pend      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ser_clk   <= (w_state_nxt == ST_SHIFT_HI);
            r_ser_latch <= (w_state_nxt == ST_LATCH);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_pend      <= w_pend_nxt;

            if (w_load) begin
                r_shift    <= w_load_data;
                r_bits     <= C_BITS;
                r_ser_data <= w_load_data[DATA_W-1];
            end else if ((r_state == ST_SHIFT_HI) && w_tick) begin
                r_shift    <= w_shifted;
                r_bits     <= r_bits - 1'b1;
                r_ser_data <= (r_bits == C_ONE) ? 1'b0 : w_shifted[DATA_W-1];
            end

            if (w_hold_wr) begin
                r_hold <= sprIn[DATA_W-1:0];
            end

            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (clrStatus) begin
                r_ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        sprOut            = '0;
        sprOut[STAT_BUSY] = r_busy;
        sprOut[STAT_PEND] = r_pend;
        sprOut[STAT_OVR]  = r_ovr;
    end

    assign serData  = r_ser_data;
    assign serClk   = r_ser_clk;
    assign serLatch = r_ser_latch;

endmodule
`default_nettype wire

// File: tb/tb_spr_serial_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_spr_serial_out
// Brief    : Directed bench for spr_serial_out (8-bit/div-2 and default builds)
// Revision : 1.0
// ============================================================================
module tb_spr_serial_out;

    localparam int CLK_PER = 10;

    logic        clk;
    logic        rst;
    logic [31:0] a_in, b_in;
    logic        a_upd, b_upd;
    logic        a_clr, b_clr;
    logic [31:0] a_out, b_out;
    logic        a_sd, a_sc, a_sl;
    logic        b_sd, b_sc, b_sl;

    int n_tests = 0;
    int n_fail  = 0;

    spr_serial_out #(.DATA_W(8), .CLK_DIV(2)) u_dut_a (
        .clk (clk), .rst (rst), .sprIn (a_in), .updateOutReg (a_upd),
        .clrStatus (a_clr), .sprOut (a_out), .serData (a_sd),
        .serClk (a_sc), .serLatch (a_sl)
    );

    spr_serial_out u_dut_b (
        .clk (clk), .rst (rst), .sprIn (b_in), .updateOutReg (b_upd),
        .clrStatus (b_clr), .sprOut (b_out), .serData (b_sd),
        .serClk (b_sc), .serLatch (b_sl)
    );

    initial clk = 1'b0;
    always #(CLK_PER / 2) clk = ~clk;

    // External 74HC595 models: shift on SRCLK rise, copy on RCLK rise.
    logic [31:0] a_sr = '0;
    logic [7:0]  a_lat_q[$];
    int          a_edges = 0;
    time         a_lat_t = 0;
    time         a_lat_w = 0;

    always @(posedge a_sc) begin
        a_sr = {a_sr[30:0], a_sd};
        a_edges++;
    end
    always @(posedge a_sl) begin
        a_lat_q.push_back(a_sr[7:0]);
        a_lat_t = $time;
    end
    always @(negedge a_sl) a_lat_w = $time - a_lat_t;

    logic [31:0] b_sr = '0;
    logic [31:0] b_cap = '0;
    int          b_edges = 0;
    time         b_last = 0;
    time         b_min = '1;
    time         b_max = 0;

    always @(posedge b_sc) begin
        b_sr = {b_sr[30:0], b_sd};
        b_edges++;
        if (b_edges > 1) begin
            if ($time - b_last < b_min) b_min = $time - b_last;
            if ($time - b_last > b_max) b_max = $time - b_last;
        end
        b_last = $time;
    end
    always @(posedge b_sl) b_cap = b_sr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lat_at(input int i);
        return (i < a_lat_q.size()) ? {24'h0, a_lat_q[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic write_a(input logic [7:0] d, output time t_edge);
        @(negedge clk);
        a_in  = {24'hABCDEF, d};
        a_upd = 1'b1;
        @(posedge clk);
        t_edge = $time;
        #1;
        a_upd = 1'b0;
    endtask

    task automatic clr_a();
        @(negedge clk);
        a_clr = 1'b1;
        @(posedge clk);
        #1;
        a_clr = 1'b0;
    endtask

    // Cycles from the write edge to the first sample with busy low.
    task automatic wait_idle_a(input time t0, output int cyc);
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (!a_out[0]) break;
        end
        cyc = int'(($time - t0 - CLK_PER / 2) / CLK_PER);
    endtask

    task automatic clear_a_model();
        a_lat_q.delete();
        a_edges = 0;
    endtask

    typedef struct {
        logic [7:0] data;
        int         exp_cyc;
        int         exp_edges;
        int         exp_lat_w;
    } vec_t;

    vec_t vecs[5];

    initial begin
        time t0;
        time t1;
        int  cyc;

        vecs[0] = '{8'hA5, 34, 8, 2 * CLK_PER};
        vecs[1] = '{8'h00, 34, 8, 2 * CLK_PER};
        vecs[2] = '{8'hFF, 34, 8, 2 * CLK_PER};
        vecs[3] = '{8'h01, 34, 8, 2 * CLK_PER};
        vecs[4] = '{8'h80, 34, 8, 2 * CLK_PER};

        rst = 1'b0; a_in = '0; b_in = '0;
        a_upd = 1'b0; b_upd = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sprOut",   a_out, 32'h0);
        chk("rst_pins",     {29'h0, a_sd, a_sc, a_sl}, 32'h0);
        chk("rst_b_sprOut", b_out, 32'h0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        chk("idle_sprOut", a_out, 32'h0);

        // Single frames from IDLE
        foreach (vecs[k]) begin
            clear_a_model();
            write_a(vecs[k].data, t0);
            @(negedge clk);
            chk("frame_busy", a_out, 32'h1);
            wait_idle_a(t0, cyc);
            chk("frame_cycles", cyc, vecs[k].exp_cyc);
            chk("frame_edges",  a_edges, vecs[k].exp_edges);
            chk("frame_latches", a_lat_q.size(), 1);
            chk("frame_data",   lat_at(0), {24'h0, vecs[k].data});
            chk("frame_lat_w",  32'(a_lat_w), vecs[k].exp_lat_w);
        end

        // Queued write during a frame
        clear_a_model();
        write_a(8'hC3, t0);
        repeat (9) @(posedge clk);
        write_a(8'h3C, t1);
        @(negedge clk);
        chk("pend_status", a_out, 32'h3);
        wait_idle_a(t0, cyc);
        chk("pend_cycles", cyc, 68);
        chk("pend_latches", a_lat_q.size(), 2);
        chk("pend_first", lat_at(0), 32'hC3);
        chk("pend_second", lat_at(1), 32'h3C);
        chk("pend_end_status", a_out, 32'h0);

        // Two queued writes: newest wins, overrun sticks until cleared
        clear_a_model();
        write_a(8'h55, t0);
        repeat (4) @(posedge clk);
        write_a(8'h11, t1);
        repeat (4) @(posedge clk);
        write_a(8'h22, t1);
        @(negedge clk);
        chk("ovr_status", a_out, 32'h7);
        clr_a();
        @(negedge clk);
        chk("ovr_cleared", a_out, 32'h3);
        wait_idle_a(t0, cyc);
        chk("ovr_cycles", cyc, 68);
        chk("ovr_first", lat_at(0), 32'h55);
        chk("ovr_second", lat_at(1), 32'h22);
        chk("ovr_latches", a_lat_q.size(), 2);

        // Write on the closing LATCH cycle with a word already queued
        clear_a_model();
        write_a(8'h12, t0);
        repeat (9) @(posedge clk);
        write_a(8'h77, t1);
        repeat (23) @(posedge clk);
        write_a(8'h99, t1);
        @(negedge clk);
        chk("edge_pend_status", a_out, 32'h5);
        wait_idle_a(t0, cyc);
        chk("edge_pend_cycles", cyc, 68);
        chk("edge_pend_first", lat_at(0), 32'h12);
        chk("edge_pend_second", lat_at(1), 32'h99);
        chk("edge_pend_latches", a_lat_q.size(), 2);
        clr_a();
        @(negedge clk);
        chk("edge_pend_clr", a_out, 32'h0);

        // Write on the closing LATCH cycle with nothing queued
        clear_a_model();
        write_a(8'h12, t0);
        repeat (33) @(posedge clk);
        write_a(8'h5A, t1);
        @(negedge clk);
        chk("edge_idle_status", a_out, 32'h1);
        wait_idle_a(t0, cyc);
        chk("edge_idle_cycles", cyc, 68);
        chk("edge_idle_second", lat_at(1), 32'h5A);
        chk("edge_idle_latches", a_lat_q.size(), 2);

        // Reset mid-frame
        clear_a_model();
        write_a(8'hF0, t0);
        repeat (14) @(posedge clk);
        #2;
        chk("pre_rst_pins", {29'h0, a_sd, a_sc, a_sl}, 32'h6);
        rst = 1'b0;
        #1;
        chk("mid_rst_pins", {29'h0, a_sd, a_sc, a_sl}, 32'h0);
        chk("mid_rst_sprOut", a_out, 32'h0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_latch", a_lat_q.size(), 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        write_a(8'h0F, t0);
        wait_idle_a(t0, cyc);
        chk("post_rst_cycles", cyc, 34);
        chk("post_rst_latches", a_lat_q.size(), 1);
        chk("post_rst_data", lat_at(0), 32'h0F);

        // Default build: 32 bits, 25-cycle half periods
        @(negedge clk);
        b_in  = 32'hDEADBEEF;
        b_upd = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1;
        b_upd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!b_out[0]) break;
        end
        cyc = int'(($time - t0 - CLK_PER / 2) / CLK_PER);
        chk("def_cycles", cyc, 1625);
        chk("def_edges", b_edges, 32);
        chk("def_min_gap", 32'(b_min), 50 * CLK_PER);
        chk("def_max_gap", 32'(b_max), 50 * CLK_PER);
        chk("def_data", b_cap, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
